// File: rtl/mem_content_tester.sv
// Memory-mapped RAM window for CPU benches.
// Returns stored words on reads and flags a match against a golden image.
module mem_content_tester #(
  parameter int unsigned addr_size  = 16,
  parameter logic [addr_size-1:0] base_addr = '0,
  parameter int unsigned array_size = 4,
  parameter int unsigned word_size  = 16,
  parameter logic [array_size*word_size-1:0] array_content = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [addr_size-1:0] addr,
  input  logic [word_size-1:0] data_in,
  input  logic                 write_en,
  output logic [word_size-1:0] data_out,
  output logic                 content_ok
);

  localparam logic [addr_size:0] size_w = (addr_size+1)'(array_size);

  logic [word_size-1:0] mem [array_size];
  logic [addr_size-1:0] offset;
  logic                 hit;
  logic [word_size-1:0] rd_word;
  logic                 match;

  // Decode the window hit; offset wraps below base, so the >= test guards it
  always_comb begin
    offset = addr - base_addr;
    hit    = (addr >= base_addr) && ({1'b0, offset} < size_w);
  end

  // Select the addressed word, zero when outside the window
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(array_size); i++) begin
      if (hit && offset == addr_size'(i)) rd_word = mem[i];
    end
  end

  // Compare the whole array against the golden image
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < int'(array_size); i++) begin
      if (mem[i] != array_content[i*word_size +: word_size]) match = 1'b0;
    end
  end

  // Array storage: writes land only on a hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(array_size); i++) mem[i] <= '0;
    end else if (write_en && hit) begin
      for (int i = 0; i < int'(array_size); i++) begin
        if (offset == addr_size'(i)) mem[i] <= data_in;
      end
    end
  end

  // Registered read and compare, both from the pre-write array state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      content_ok <= 1'b0;
    end else begin
      data_out   <= rd_word;
      content_ok <= match;
    end
  end

endmodule

// File: tb/tb_mem_content_tester.sv
// Scoreboard bench for mem_content_tester.
// A reference array predicts data_out/content_ok per access.
module tb_mem_content_tester;

  localparam logic [7:0]  base   = 8'h80;
  localparam logic [23:0] golden = 24'h640700;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       write_en = 1'b0;
  logic [7:0] data_out;
  logic       content_ok;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] d;
    logic       ok;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [3];

  mem_content_tester #(
    .addr_size(8),
    .base_addr(base),
    .array_size(3),
    .word_size(8),
    .array_content(golden)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .data_in(data_in),
    .write_en(write_en),
    .data_out(data_out),
    .content_ok(content_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ok();
    logic [23:0] g;
    g = golden;
    for (int i = 0; i < 3; i++)
      if (model[i] != g[i*8 +: 8]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic op(input string tag, input logic [7:0] a,
                    input logic [7:0] d, input logic we);
    exp_t e;
    int   idx;
    logic h;
    addr = a;
    data_in = d;
    write_en = we;
    h = (a >= 8'h80) && (a <= 8'h82);
    idx = int'(a) - 128;
    e.tag = tag;
    e.d = h ? model[idx] : 8'h00;
    e.ok = model_ok();
    sb.push_back(e);
    if (we && h) model[idx] = d;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".d"}, 32'(data_out), 32'(e.d));
    check({e.tag, ".ok"}, 32'(content_ok), 32'(e.ok));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) model[i] = '0;
    #2;
    check("rst.d", 32'(data_out), 32'h0);
    check("rst.ok", 32'(content_ok), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    op("idle0", 8'h00, 8'h00, 1'b0);
    op("idle1", 8'h00, 8'h00, 1'b0);
    check("idle.ok", 32'(content_ok), 32'h0);

    op("w80", 8'h80, 8'h00, 1'b1);
    op("w81", 8'h81, 8'h07, 1'b1);
    op("w82", 8'h82, 8'h64, 1'b1);
    op("r81", 8'h81, 8'h00, 1'b0);
    check("match.ok", 32'(content_ok), 32'h1);
    check("r81.lit", 32'(data_out), 32'h07);

    op("brk", 8'h82, 8'h65, 1'b1);
    op("brk1", 8'h82, 8'h00, 1'b0);
    check("brk.ok", 32'(content_ok), 32'h0);
    op("fix", 8'h82, 8'h64, 1'b1);
    op("fix1", 8'h80, 8'h00, 1'b0);
    check("fix.ok", 32'(content_ok), 32'h1);

    op("w7f", 8'h7f, 8'hff, 1'b1);
    op("w83", 8'h83, 8'hff, 1'b1);
    op("r00", 8'h00, 8'h00, 1'b0);
    op("r7f", 8'h7f, 8'h00, 1'b0);
    op("r83", 8'h83, 8'h00, 1'b0);
    op("rff", 8'hff, 8'h00, 1'b0);
    op("r82", 8'h82, 8'h00, 1'b0);
    check("oor.ok", 32'(content_ok), 32'h1);

    op("col", 8'h81, 8'haa, 1'b1);
    check("col.lit", 32'(data_out), 32'h07);
    op("colr", 8'h81, 8'h00, 1'b0);
    check("colr.lit", 32'(data_out), 32'haa);
    op("rest", 8'h81, 8'h07, 1'b1);
    op("rest1", 8'h82, 8'h00, 1'b0);
    op("rest2", 8'h82, 8'h00, 1'b0);
    check("pre.d", 32'(data_out), 32'h64);
    check("pre.ok", 32'(content_ok), 32'h1);

    #2;
    reset = 1'b1;
    #1;
    check("arst.d", 32'(data_out), 32'h0);
    check("arst.ok", 32'(content_ok), 32'h0);
    for (int i = 0; i < 3; i++) model[i] = '0;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    op("pr80", 8'h80, 8'h00, 1'b0);
    op("pr81", 8'h81, 8'h00, 1'b0);
    op("pr82", 8'h82, 8'h00, 1'b0);
    op("pr83", 8'h80, 8'h00, 1'b0);

    check("sb.empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_content_tester.md
Name: mem_content_tester

Overview:
- Small memory-mapped RAM window used in CPU simulation benches.
- Stores bus writes that fall in [base_addr, base_addr+array_size-1] and returns the stored words on reads.
- Continuously compares its whole content against a parameter-supplied golden image and raises content_ok when they match.
- Sits on the CPU data bus beside the program ROM. Its read data is OR-ed with the ROM output, so it drives zero when not addressed.

Parameters:
- base_addr, 0, first bus address of the window (addr_size bits).
- addr_size, 16, width of the address bus.
- array_size, 4, number of words in the window (≥1).
- word_size, 16, data width in bits.
- array_content, 0, golden image, array_size*word_size bits wide. Word i is array_content[i*word_size +: word_size], so word 0 is in the LSBs.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  addr_size  bus address.
- data_in  input  word_size  write data from the CPU.
- write_en  input  1  write strobe, sampled on the clk rising edge.
- data_out  output  word_size  registered read data; zero when not addressed.
- content_ok  output  1  high when every stored word equals its golden word.

Behaviour:
- Hit decode (combinational):
  - hit = (addr >= base_addr) and (addr - base_addr < array_size), compared as unsigned addr_size-bit values.
  - No wrap-around: addresses below base_addr never hit, and neither do addresses at or beyond base_addr+array_size.
  - index = addr - base_addr.
- Reset (asynchronous, while reset=1):
  - all array words = 0
  - data_out = 0
  - content_ok = 0
  - writes ignored
- Write: on a rising edge with write_en=1 and hit=1, mem[index] <= data_in.
  - write_en=1 with hit=0 has no effect.
- Read:
  - On every rising edge, data_out <= hit ? mem[index] : 0.
  - This is 1-cycle latency, the same timing as the program ROM.
  - Reads happen regardless of write_en.
- Read/write collision: with write_en=1 and hit=1, data_out captures the old word (read-before-write). The new word is visible on the next access.
- Compare:
  - On every rising edge, content_ok <= (mem[i] == golden word i for all i in 0..array_size-1).
  - It uses the array state before that edge's write, so content_ok rises one cycle after the last matching write lands.
  - It falls likewise one cycle after any write that breaks the match.
- content_ok after reset release:
  - It goes high on the first clock edge after reset release only if the golden image is all zeros.
  - Otherwise it stays low until the content matches.
- Reset asserted mid-operation immediately clears the array, data_out and content_ok, with no clock needed.
- No other state: no FSM, no counters.

Test Plan:
- Reset then idle. Use base_addr=0x80, addr_size=8, array_size=3, word_size=8, array_content=0x640700. Assert reset -> data_out=0, content_ok=0. Release reset and clock 2 cycles -> content_ok stays 0, because word 0 = 0x00 but word 1 = 0x07 is not 0.
- Golden match. Write 0x00@0x80, 0x07@0x81, 0x64@0x82 -> content_ok=1 one cycle after the third write. Reads of 0x81 return 0x07 one cycle after the address is presented.
- Break match. Then write 0x65@0x82 -> content_ok=0 the next cycle. Rewrite 0x64 -> content_ok=1 again.
- Out-of-range addresses:
  - Writing 0xFF to 0x7F and 0x83 leaves content unchanged and content_ok unaffected.
  - Reads at 0x00, 0x7F and 0x83 give data_out=0.
- Collision. Present write_en=1, addr=0x81, data_in=0xAA while mem[1]=0x07 -> data_out=0x07 after the edge. The following read of 0x81 gives 0xAA.
- Async reset mid-run. Pulse reset between clock edges while content_ok=1 -> data_out and content_ok drop to 0 immediately. After release, reads of 0x80..0x82 return 0.
